// File: rtl/adc_if_pkg.sv
// Shared defaults, FSM state encoding and checkerboard constants for the
// AD9284 input-delay calibration logic.
package adc_if_pkg;

  localparam int CAL_LANES  = 8;
  localparam int CAL_TAP_W  = 5;
  localparam int CAL_N_TAPS = 1 << CAL_TAP_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    EVAL,
    APPLY,
    DONE
  } cal_state_t;

  // Checkerboard test mode: rise samples always see 0x55, fall samples 0xAA.
  localparam logic [7:0] CHECKER_RISE = 8'h55;
  localparam logic [7:0] CHECKER_FALL = 8'hAA;

endpackage

// File: rtl/adc_delay_calib_tracker.sv
// Per-lane tracker of the current passing run and the widest run seen so far.
// The first (lowest-tap) window wins ties because replacement needs a strictly longer run.
module adc_lane_window_tracker
  import adc_if_pkg::*;
#(
  parameter int TAP_W = CAL_TAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             eval,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] run_start;
  logic [TAP_W-1:0] run_start_nxt;
  logic [TAP_W:0]   run_len;
  logic [TAP_W:0]   run_len_nxt;

  always_comb begin
    run_start_nxt = run_start;
    run_len_nxt   = '0;
    if (pass) begin
      run_start_nxt = (run_len == '0) ? tap : run_start;
      run_len_nxt   = run_len + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (eval) begin
      run_start <= run_start_nxt;
      run_len   <= run_len_nxt;
      if (pass && (run_len_nxt > best_len)) begin
        best_start <= run_start_nxt;
        best_len   <= run_len_nxt;
      end
    end
  end

endmodule

// File: rtl/adc_delay_calib.sv
// IDELAY calibration controller: sweeps every tap with the ADC in checkerboard
// mode, scores each lane per tap and loads each lane with its widest window's centre.
module adc_delay_calib
  import adc_if_pkg::*;
#(
  parameter int LANES         = CAL_LANES,
  parameter int TAP_W         = CAL_TAP_W,
  parameter int SETTLE_CYCLES = 16,
  parameter int CHECK_CYCLES  = 64
) (
  input  logic                   adc_dco_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   idelayctrl_rdy,
  input  logic [LANES-1:0]       data_rise,
  input  logic [LANES-1:0]       data_fall,
  output logic [LANES-1:0]       delay_ld,
  output logic [LANES*TAP_W-1:0] delay_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [LANES-1:0]       lane_ok,
  output logic                   cal_error
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + CHECK_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_LAST    = '1;

  cal_state_t             state_q;
  cal_state_t             state_nxt;
  logic                   accept;
  logic [CNT_W-1:0]       cyc_q;
  logic [TAP_W-1:0]       tap_q;
  logic [TAP_W-1:0]       tap_nxt;
  logic [LANES-1:0]       rise_q;
  logic [LANES-1:0]       fail_q;
  logic [LANES-1:0]       bad;
  logic [LANES-1:0]       ok_nxt;
  logic [LANES*TAP_W-1:0] wdata_q;
  logic [LANES*TAP_W-1:0] centre;
  logic [TAP_W-1:0]       best_start [LANES];
  logic [TAP_W:0]         best_len   [LANES];

  // A sample is bad if the DDR halves match or the rise half moved since last cycle.
  assign bad = (data_rise ~^ data_fall) | (data_rise ^ rise_q);

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    tap_nxt   = tap_q;
    case (state_q)
      IDLE, DONE: begin
        if (start && idelayctrl_rdy) begin
          accept    = 1'b1;
          tap_nxt   = '0;
          state_nxt = LOAD;
        end
      end
      LOAD:   state_nxt = SETTLE;
      SETTLE: if (cyc_q == SETTLE_LAST) state_nxt = CHECK;
      CHECK:  if (cyc_q == CHECK_LAST) state_nxt = EVAL;
      EVAL: begin
        if (tap_q == TAP_LAST) begin
          state_nxt = APPLY;
        end else begin
          tap_nxt   = tap_q + 1'b1;
          state_nxt = LOAD;
        end
      end
      APPLY:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    adc_lane_window_tracker #(.TAP_W(TAP_W)) u_tracker (
      .clk        (adc_dco_clk),
      .reset      (reset),
      .clear      (accept),
      .eval       (state_q == EVAL),
      .pass       (~fail_q[i]),
      .tap        (tap_q),
      .best_start (best_start[i]),
      .best_len   (best_len[i])
    );
    assign ok_nxt[i] = (best_len[i] != '0);
    assign centre[i*TAP_W +: TAP_W] =
      ok_nxt[i] ? (best_start[i] + TAP_W'(best_len[i] >> 1)) : '0;
  end

  // The trackers settle on the final EVAL edge, so APPLY drives the centres directly.
  assign delay_wdata = (state_q == APPLY) ? centre : wdata_q;

  always_ff @(posedge adc_dco_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      tap_q     <= '0;
      rise_q    <= '0;
      fail_q    <= '0;
      wdata_q   <= '0;
      delay_ld  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lane_ok   <= '0;
      cal_error <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      tap_q    <= tap_nxt;
      rise_q   <= data_rise;
      cyc_q    <= ((state_nxt == state_q) && ((state_q == SETTLE) || (state_q == CHECK)))
                  ? cyc_q + 1'b1 : '0;
      busy     <= !((state_nxt == IDLE) || (state_nxt == DONE));
      done     <= (state_nxt == DONE);
      delay_ld <= ((state_nxt == LOAD) || (state_nxt == APPLY)) ? '1 : '0;
      if (state_nxt == LOAD) wdata_q <= {LANES{tap_nxt}};
      if (state_q == APPLY) begin
        wdata_q   <= centre;
        lane_ok   <= ok_nxt;
        cal_error <= ~&ok_nxt;
      end
      if (accept) begin
        fail_q    <= '0;
        lane_ok   <= '0;
        cal_error <= 1'b0;
      end else if (state_q == CHECK) begin
        fail_q <= fail_q | bad;
      end else if (state_q == EVAL) begin
        fail_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_delay_calib.sv
// Directed bench for adc_delay_calib: an IDELAY/ADC model per lane feeds the
// checkerboard or a bad pattern depending on the lane's currently loaded tap.
module tb_adc_delay_calib;
  import adc_if_pkg::*;

  localparam int LANES      = 8;
  localparam int TAP_W      = 5;
  localparam int RUN_CYCLES = 2625;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   rdy;
  logic [LANES-1:0]       data_rise = '0;
  logic [LANES-1:0]       data_fall = '0;
  logic [LANES-1:0]       delay_ld;
  logic [LANES*TAP_W-1:0] delay_wdata;
  logic                   busy;
  logic                   done;
  logic [LANES-1:0]       lane_ok;
  logic                   cal_error;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0]      pass_map [LANES];
  logic [LANES-1:0] toggle_bad = '0;
  logic [TAP_W-1:0] cur_tap [LANES] = '{default: '0};
  logic             tog = 1'b0;
  logic [7:0]       cb_rise = CHECKER_RISE;
  logic [7:0]       cb_fall = CHECKER_FALL;

  always #5 clk = ~clk;

  adc_delay_calib dut (
    .adc_dco_clk    (clk),
    .reset          (rst),
    .start          (start),
    .idelayctrl_rdy (rdy),
    .data_rise      (data_rise),
    .data_fall      (data_fall),
    .delay_ld       (delay_ld),
    .delay_wdata    (delay_wdata),
    .busy           (busy),
    .done           (done),
    .lane_ok        (lane_ok),
    .cal_error      (cal_error)
  );

  // IDELAY model: a lane takes its new tap on the edge that ends the load strobe.
  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (delay_ld[i]) cur_tap[i] <= delay_wdata[i*TAP_W +: TAP_W];
  end

  // Data model: good taps see the checkerboard; bad taps are stuck low or jittering.
  always @(negedge clk) begin
    tog = ~tog;
    for (int i = 0; i < LANES; i++) begin
      if (pass_map[i][cur_tap[i]]) begin
        data_rise[i] = cb_rise[i];
        data_fall[i] = cb_fall[i];
      end else if (toggle_bad[i]) begin
        data_rise[i] = tog;
        data_fall[i] = ~tog;
      end else begin
        data_rise[i] = 1'b0;
        data_fall[i] = 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_window(input int lane, input int lo, input int hi);
    for (int t = lo; t <= hi; t++) pass_map[lane][t] = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_cal(input logic [LANES*TAP_W-1:0] exp_w, input logic [LANES-1:0] exp_ok,
                         input logic exp_err, input bit poke_start);
    int n;
    int ld_cnt;
    logic [LANES*TAP_W-1:0] last_w;
    pulse_start();
    check_val("busy_after_start", busy, 1);
    check_val("ld_tap0", delay_ld, 8'hFF);
    check_val("wdata_tap0", delay_wdata, 0);
    n      = 0;
    ld_cnt = 1;
    last_w = '0;
    while (!done && n < RUN_CYCLES + 100) begin
      @(posedge clk);
      #1;
      n++;
      start = (poke_start && n == 500);
      if (delay_ld != '0) begin
        ld_cnt++;
        last_w = delay_wdata;
      end
    end
    check_val("run_cycles", n, RUN_CYCLES);
    check_val("ld_pulses", ld_cnt, 33);
    check_val("apply_wdata", last_w, exp_w);
    check_val("final_wdata", delay_wdata, exp_w);
    check_val("lane_ok", lane_ok, exp_ok);
    check_val("cal_error", cal_error, exp_err);
    check_val("busy_done", busy, 0);
    @(posedge clk);
    #1;
    check_val("ld_after_apply", delay_ld, 0);
    check_val("done_held", done, 1);
  endtask

  initial begin
    int ld_seen;
    rst   = 1'b1;
    start = 1'b0;
    rdy   = 1'b1;
    for (int i = 0; i < LANES; i++) pass_map[i] = '1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_lane_ok", lane_ok, 0);
    check_val("rst_cal_error", cal_error, 0);
    check_val("rst_ld", delay_ld, 0);
    check_val("rst_wdata", delay_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // All lanes ideal: full 32-tap window, centre 16.
    run_cal({8{5'd16}}, 8'hFF, 1'b0, 1'b0);

    // Lane 0: 2..5 and 12..17 -> 15. Lane 1: 4..7 and 20..23 -> 6. Lane 3: 10..20 -> 15. Lane 7 dead.
    for (int i = 0; i < LANES; i++) pass_map[i] = '1;
    pass_map[0] = '0; add_window(0, 2, 5);  add_window(0, 12, 17);
    pass_map[1] = '0; add_window(1, 4, 7);  add_window(1, 20, 23);
    pass_map[3] = '0; add_window(3, 10, 20);
    toggle_bad[3] = 1'b1;
    pass_map[7] = '0;
    run_cal({5'd0, 5'd16, 5'd16, 5'd16, 5'd15, 5'd16, 5'd6, 5'd15}, 8'h7F, 1'b1, 1'b0);

    // start without IDELAYCTRL ready is ignored.
    @(negedge clk);
    rdy = 1'b0;
    pulse_start();
    check_val("nordy_busy", busy, 0);
    check_val("nordy_done", done, 1);
    repeat (3) @(posedge clk);
    #1;
    check_val("nordy_busy_later", busy, 0);
    @(negedge clk);
    rdy = 1'b1;

    // Abort during tap 9.
    pulse_start();
    ld_seen = (delay_ld != '0) ? 1 : 0;
    for (int c = 0; c < 2000 && ld_seen < 10; c++) begin
      @(posedge clk);
      #1;
      if (delay_ld != '0) ld_seen++;
    end
    check_val("reached_tap9", ld_seen, 10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_lane_ok", lane_ok, 0);
    check_val("abort_cal_error", cal_error, 0);
    check_val("abort_ld", delay_ld, 0);
    check_val("abort_wdata", delay_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh sweep after abort, with a stray start mid-run that must be ignored.
    run_cal({5'd0, 5'd16, 5'd16, 5'd16, 5'd15, 5'd16, 5'd6, 5'd15}, 8'h7F, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
